fifo_rd_chk: RTL and testbench

FIFO_RD_CHK -- requirements
Module: fifo_rd_chk

---
 rtl/fifo_rd_chk.sv | 160 ++++++++++++++++
 tb/tb_fifo_rd_chk.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_chk.sv
// Read-side controller for a FIFO filled by a wrapping counter producer.
// Waits for full, drains the FIFO in one burst and checks the word sequence.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | read side held in reset by rd_rst_busy, or just out of rst
// WAIT_FULL | waiting for the synchronized full flag
// READ      | issuing fifo_rd_en while the FIFO has data
// DRAIN     | RD_LAT cycles for the last read to leave the FIFO pipeline
module fifo_rd_chk #(
    parameter int DATA_W   = 8,
    parameter int WRAP_MAX = 254,
    parameter int RD_LAT   = 1
) (
    input  logic              rd_clk,
    input  logic              rst,
    input  logic              rd_rst_busy,
    input  logic              full,
    input  logic              almost_empty,
    input  logic              empty,
    input  logic [DATA_W-1:0] fifo_rd_data,
    output logic              fifo_rd_en,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              err_flag,
    output logic [15:0]       err_cnt,
    output logic [15:0]       burst_cnt
);

    typedef enum logic [1:0] {IDLE, WAIT_FULL, READ, DRAIN} state_t;

    localparam logic [DATA_W-1:0] WRAP_LIM   = DATA_W'(WRAP_MAX);
    localparam logic [1:0]        DRAIN_LOAD = 2'(RD_LAT - 1);

    state_t              state_q, state_d;
    logic [1:0]          drain_q, drain_d;
    logic                burst_done;
    logic                enter_read;

    logic                full_meta_q, full_d1_q;
    logic [RD_LAT-1:0]   vld_pipe_q;
    logic [RD_LAT:0]     vld_sr;
    logic                rd_valid_q;
    logic [DATA_W-1:0]   rd_data_q;

    logic [DATA_W-1:0]   exp_q, exp_d;
    logic                resync_q, resync_d;
    logic                err_flag_q, err_flag_d;
    logic [15:0]         err_cnt_q, err_cnt_d;
    logic [15:0]         burst_cnt_q, burst_cnt_d;

    function automatic logic [DATA_W-1:0] next_val(input logic [DATA_W-1:0] x);
        if (x >= WRAP_LIM)
            return '0;
        return x + DATA_W'(1);
    endfunction

    always_ff @(posedge rd_clk) begin
        if (rst) begin
            state_q <= IDLE;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        drain_d    = drain_q;
        burst_done = 1'b0;
        if (rd_rst_busy) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:      state_d = WAIT_FULL;
                WAIT_FULL: if (full_d1_q) state_d = READ;
                READ: begin
                    if (empty || (fifo_rd_en && almost_empty)) begin
                        state_d = DRAIN;
                        drain_d = DRAIN_LOAD;
                    end
                end
                DRAIN: begin
                    if (drain_q == 2'd0) begin
                        state_d    = WAIT_FULL;
                        burst_done = 1'b1;
                    end else begin
                        drain_d = drain_q - 2'd1;
                    end
                end
                default:   state_d = IDLE;
            endcase
        end
    end

    // Read enable is combinational so empty/busy cut it in the same cycle.
    always_comb begin
        fifo_rd_en = (state_q == READ) && !empty && !rd_rst_busy && !rst;
    end

    assign enter_read = (state_q == WAIT_FULL) && (state_d == READ);

    // vld_sr[RD_LAT] marks the cycle fifo_rd_data carries a requested word.
    assign vld_sr = {vld_pipe_q, fifo_rd_en};

    always_comb begin
        exp_d       = exp_q;
        resync_d    = resync_q;
        err_flag_d  = err_flag_q;
        err_cnt_d   = err_cnt_q;
        burst_cnt_d = burst_cnt_q + (burst_done ? 16'd1 : 16'd0);
        if (rd_valid_q) begin
            exp_d = next_val(rd_data_q);
            if (resync_q) begin
                resync_d = 1'b0;
            end else if (rd_data_q != exp_q) begin
                err_flag_d = 1'b1;
                if (err_cnt_q != 16'hFFFF)
                    err_cnt_d = err_cnt_q + 16'd1;
            end
        end
        if (enter_read)
            resync_d = 1'b1;
    end

    always_ff @(posedge rd_clk) begin
        if (rst) begin
            full_meta_q <= 1'b0;
            full_d1_q   <= 1'b0;
            vld_pipe_q  <= '0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            exp_q       <= '0;
            resync_q    <= 1'b1;
            err_flag_q  <= 1'b0;
            err_cnt_q   <= '0;
            burst_cnt_q <= '0;
        end else begin
            full_meta_q <= full;
            full_d1_q   <= full_meta_q;
            vld_pipe_q  <= vld_sr[RD_LAT-1:0];
            rd_valid_q  <= vld_sr[RD_LAT];
            if (vld_sr[RD_LAT])
                rd_data_q <= fifo_rd_data;
            exp_q       <= exp_d;
            resync_q    <= resync_d;
            err_flag_q  <= err_flag_d;
            err_cnt_q   <= err_cnt_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign err_flag  = err_flag_q;
    assign err_cnt   = err_cnt_q;
    assign burst_cnt = burst_cnt_q;

endmodule

// File: tb/tb_fifo_rd_chk.sv
// Directed bench for fifo_rd_chk with a behavioural latency-1 FIFO.
module tb_fifo_rd_chk;

    logic        rd_clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd_rst_busy = 1'b0;
    logic        full = 1'b0;
    logic        force_empty = 1'b0;
    logic        fifo_clear = 1'b0;
    logic        almost_empty, empty;
    logic [7:0]  fifo_rd_data = 8'h00;
    logic        fifo_rd_en, rd_valid, err_flag;
    logic [7:0]  rd_data;
    logic [15:0] err_cnt, burst_cnt;

    logic [7:0]  mem [0:65599];
    int          n_words = 0;
    int          rd_ptr = 0;
    int          bad_rd = 0;

    int          n_chk = 0, n_err = 0;
    int          cyc = 0, en_cnt = 0, first_en_cyc = -1, first_vld_cyc = -1;
    logic        prev_valid = 1'b0;
    logic [7:0]  got_q[$];
    logic [15:0] err_after_q[$];

    fifo_rd_chk #(.DATA_W(8), .WRAP_MAX(254), .RD_LAT(1)) dut (
        .rd_clk       (rd_clk),
        .rst          (rst),
        .rd_rst_busy  (rd_rst_busy),
        .full         (full),
        .almost_empty (almost_empty),
        .empty        (empty),
        .fifo_rd_data (fifo_rd_data),
        .fifo_rd_en   (fifo_rd_en),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .err_flag     (err_flag),
        .err_cnt      (err_cnt),
        .burst_cnt    (burst_cnt)
    );

    always #5 rd_clk = ~rd_clk;

    assign empty        = force_empty || (rd_ptr >= n_words);
    assign almost_empty = (n_words - rd_ptr) <= 1;

    always @(posedge rd_clk) begin
        if (fifo_rd_en && (empty || rd_rst_busy))
            bad_rd <= bad_rd + 1;
        if (fifo_clear)
            rd_ptr <= 0;
        else if (fifo_rd_en && (rd_ptr < n_words)) begin
            fifo_rd_data <= mem[rd_ptr];
            rd_ptr       <= rd_ptr + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge rd_clk);
        #1;
        cyc++;
        if (prev_valid)
            err_after_q.push_back(err_cnt);
        prev_valid = rd_valid;
        if (rd_valid) begin
            got_q.push_back(rd_data);
            if (first_vld_cyc < 0) first_vld_cyc = cyc;
        end
        if (fifo_rd_en) begin
            en_cnt++;
            if (first_en_cyc < 0) first_en_cyc = cyc;
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_obs();
        got_q.delete();
        err_after_q.delete();
        prev_valid    = 1'b0;
        first_en_cyc  = -1;
        first_vld_cyc = -1;
    endtask

    task automatic fifo_load(input int n);
        n_words    = n;
        fifo_clear = 1'b1;
        tick();
        fifo_clear = 1'b0;
    endtask

    task automatic pulse_full();
        full = 1'b1;
        tick();
        full = 1'b0;
    endtask

    task automatic wait_en(input int target, input int budget, input string tag);
        int k = 0;
        while (en_cnt < target && k < budget) begin
            tick();
            k++;
        end
        if (en_cnt < target)
            chk({tag, "_timeout"}, en_cnt, target);
    endtask

    task automatic check_got(input string tag, input int n);
        chk({tag, "_nwords"}, got_q.size(), n);
        for (int i = 0; i < n && i < got_q.size(); i++)
            chk({tag, "_word"}, got_q[i], mem[i]);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_rd_en"},  fifo_rd_en, 0);
        chk({tag, "_valid"},  rd_valid,   0);
        chk({tag, "_data"},   rd_data,    0);
        chk({tag, "_flag"},   err_flag,   0);
        chk({tag, "_errcnt"}, err_cnt,    0);
        chk({tag, "_burst"},  burst_cnt,  0);
    endtask

    initial begin
        int t0, e0, e1;
        logic [15:0] exp_hist [5];
        exp_hist = '{16'd0, 16'd0, 16'd1, 16'd2, 16'd2};

        // reset state
        ticks(2);
        check_all_zero("reset");
        rst = 1'b0;

        // normal burst 0..15
        for (int i = 0; i < 16; i++) mem[i] = 8'(i);
        fifo_load(16);
        clear_obs();
        e0 = en_cnt;
        t0 = cyc;
        pulse_full();
        ticks(30);
        chk("t1_full_to_en", first_en_cyc - t0, 3);
        chk("t1_en_to_valid", first_vld_cyc - first_en_cyc, 2);
        chk("t1_en_cycles", en_cnt - e0, 16);
        check_got("t1", 16);
        chk("t1_errcnt", err_cnt, 0);
        chk("t1_flag", err_flag, 0);
        chk("t1_burst", burst_cnt, 1);

        // wrap 254 -> 0
        mem[0] = 8'd250; mem[1] = 8'd251; mem[2] = 8'd252; mem[3] = 8'd253;
        mem[4] = 8'd254; mem[5] = 8'd0;   mem[6] = 8'd1;
        fifo_load(7);
        clear_obs();
        pulse_full();
        ticks(20);
        check_got("t2", 7);
        chk("t2_errcnt", err_cnt, 0);
        chk("t2_burst", burst_cnt, 2);

        // single corruption
        mem[0] = 8'd10; mem[1] = 8'd11; mem[2] = 8'd99; mem[3] = 8'd13; mem[4] = 8'd14;
        fifo_load(5);
        clear_obs();
        pulse_full();
        ticks(20);
        check_got("t3", 5);
        chk("t3_hist_n", err_after_q.size(), 5);
        for (int i = 0; i < 5 && i < err_after_q.size(); i++)
            chk("t3_errcnt_after_word", err_after_q[i], exp_hist[i]);
        chk("t3_flag", err_flag, 1);
        chk("t3_burst", burst_cnt, 3);

        // empty forced mid-READ
        for (int i = 0; i < 10; i++) mem[i] = 8'(20 + i);
        fifo_load(10);
        clear_obs();
        e0 = en_cnt;
        pulse_full();
        wait_en(e0 + 3, 20, "t4_wait");
        force_empty = 1'b1;
        #1;
        chk("t4_en_drop", fifo_rd_en, 0);
        tick();
        chk("t4_reads", rd_ptr, 2);
        force_empty = 1'b0;
        e1 = en_cnt;
        ticks(10);
        chk("t4_no_resume", en_cnt - e1, 0);
        chk("t4_burst", burst_cnt, 4);
        check_got("t4", 2);
        chk("t4_errcnt", err_cnt, 2);
        chk("t4_flag_sticky", err_flag, 1);

        // rd_rst_busy abort after 5 reads
        for (int i = 0; i < 10; i++) mem[i] = 8'(30 + i);
        fifo_load(10);
        clear_obs();
        e0 = en_cnt;
        pulse_full();
        wait_en(e0 + 6, 20, "t5_wait");
        rd_rst_busy = 1'b1;
        #1;
        chk("t5_en_drop", fifo_rd_en, 0);
        e1 = en_cnt;
        ticks(4);
        rd_rst_busy = 1'b0;
        ticks(6);
        chk("t5_no_reads", en_cnt - e1, 0);
        chk("t5_reads", rd_ptr, 5);
        chk("t5_burst", burst_cnt, 4);
        check_got("t5", 5);
        chk("t5_errcnt", err_cnt, 2);

        // saturation: 255 is above WRAP_MAX, every word after resync mismatches
        for (int i = 0; i < 65540; i++) mem[i] = 8'hFF;
        fifo_load(65540);
        clear_obs();
        pulse_full();
        begin
            int k = 0;
            while (rd_ptr < 65540 && k < 65600) begin
                tick();
                k++;
            end
            if (rd_ptr < 65540)
                chk("t6_timeout", rd_ptr, 65540);
        end
        ticks(5);
        chk("t6_errcnt_sat", err_cnt, 16'hFFFF);
        chk("t6_flag", err_flag, 1);
        chk("t6_burst", burst_cnt, 5);

        // reset in the middle of a burst
        for (int i = 0; i < 10; i++) mem[i] = 8'(40 + i);
        fifo_load(10);
        clear_obs();
        e0 = en_cnt;
        pulse_full();
        wait_en(e0 + 3, 20, "t7_wait");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_all_zero("t7_after_rst");
        clear_obs();
        e1 = en_cnt;
        ticks(8);
        chk("t7_no_valid", got_q.size(), 0);
        chk("t7_no_reads", en_cnt - e1, 0);

        chk("rd_while_empty_or_busy", bad_rd, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
